ddr_prbs_checker: RTL
=====================

# ddr_prbs_checker

Downstream checker for the DDR input throughput test. Consumes the rising- and falling-edge bit pair captured each clock by the DDR input stage and verifies it against the 5-bit XNOR PRBS (next = ~(s[4] ^ s[2])) that the stimulus source transmits. The checker is self-synchronising, acquires and tracks lock, and accumulates saturating bit and error counts that the top level multiplexes onto output pins.

## Interface
Parameters:
- CNT_W, 16, width of `bit_count` and `err_count`.
- LOCK_GOOD, 8, consecutive error-free valid cycles required in HUNT before entering LOCKED (1..255).
- LOSS_ERR, 4, error-bit count within one 32-cycle LOCKED window that forces a return to HUNT (1..64).

Ports:
- clk  in  1  the design's single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of `bit_count`, `err_count` and the sticky `err_seen`; the FSM is unaffected.
- in_valid  in  1  `d_rise`/`d_fall` hold a new sample pair this cycle.
- d_rise  in  1  bit captured on the rising edge; first in stream order.
- d_fall  in  1  bit captured on the falling edge; second in stream order.
- locked  out  1  FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse for any mismatch counted in the previous cycle.
- err_seen  out  1  sticky; set by the first counted error.
- bit_count  out  CNT_W  bits checked while LOCKED; saturating.
- err_count  out  CNT_W  mismatching bits while LOCKED; saturating.
- state  out  2  FSM encoding for debug: FILL=0, HUNT=1, LOCKED=2.

## Operation
- History register `h[4:0]` holds the last five received bits; `h[0]` is the newest.
- On each in_valid cycle, predictions use received data, not predicted data:
  - exp_r = ~(h[4] ^ h[2]); err_r = d_rise != exp_r.
  - g = {h[3:0], d_rise}; exp_f = ~(g[4] ^ g[2]); err_f = d_fall != exp_f.
  - h <= {h[2:0], d_rise, d_fall}.
- A single flipped line bit produces up to three mismatches (itself plus its two downstream taps). This is accepted and not corrected.
- Stuck-high guard: the all-ones history is the XNOR lock-up state and self-predicts. A cycle is "stuck" when h == 5'b11111 and d_rise = d_fall = 1. A stuck cycle counts as erroneous for lock purposes in every state.
- FSM:
  - FILL: counts in_valid cycles in `fill_cnt[1:0]`. Performs no checking. After the 3rd valid cycle (6 bits received), go to HUNT.
  - HUNT: `good_cnt` increments on a valid cycle with !err_r && !err_f && !stuck. Any other valid cycle clears it. When `good_cnt` reaches LOCK_GOOD, go to LOCKED, clear `good_cnt`, and start a new window.
  - LOCKED: each valid cycle adds 2 to `bit_count` and err_r + err_f + 2·stuck to `err_count` and to the window error counter `win_err` (7 bits, saturating). `win_cnt[4:0]` counts valid cycles.
    - If win_err ≥ LOSS_ERR after the update, go to HUNT with `good_cnt` = 0.
    - Otherwise, when win_cnt wraps 31→0, clear win_err.
- Counters saturate at all-ones. They never wrap.
- in_valid = 0: no register changes except clr and the err_pulse deassertion.
- clr together with a counted error in the same cycle: clr wins. Counters read 0 and err_seen reads 0. err_pulse still fires.
- Counts are accumulated only in LOCKED. HUNT/FILL errors affect only `good_cnt`.

## Timing
- All outputs are registered. An error on the bus at edge N is visible on err_pulse/err_count/err_seen after edge N, and err_pulse drops after edge N+1 unless a new error occurs.
- Entering LOCKED: `locked` rises on the edge that consumes the LOCK_GOOD-th good cycle. The next valid cycle is the first counted one.
- Losing lock: `locked` falls on the same edge that counts the threshold-crossing error. That error is included in err_count.
- Reset (async assert, sync-safe release): state=FILL, h=0, fill/good/win counters 0, locked=0, err_pulse=0, err_seen=0, bit_count=0, err_count=0.
- Reset asserted mid-LOCKED discards all history. Re-acquisition needs 3 + LOCK_GOOD valid cycles minimum.

## Test plan
- Clean PRBS from seed 0, in_valid every cycle, defaults: locked rises after cycle 11. After 100 further cycles, bit_count=200, err_count=0, err_seen=0.
- Single line-bit flip while LOCKED (rise bit, not within the last 2 bits of a window): err_count=3, err_seen=1, err_pulse high for exactly the affected cycles, locked stays 1.
- Burst of 4 consecutive flipped rise bits while LOCKED: err_count ≥ 4 within 4 cycles, locked drops on the crossing edge, state=HUNT. Clean data resumes → relock after 8 good cycles.
- Constant 1 input after reset: never leaves HUNT, locked=0. Constant 0 input: errors every cycle, never locks.
- bit_count preload near saturation (CNT_W=4): stays at 4'hF after overflow. clr with a simultaneous error: counters 0, err_seen 0, err_pulse 1.
- in_valid toggled 1/0 with clean PRBS: lock after 11 valid cycles regardless of gaps. Async rst asserted mid-LOCKED: all outputs 0 / state=FILL on assertion, without waiting for clk.

Source files
------------

// File: rtl/ddr_prbs_checker.sv
// rtl/ddr_prbs_checker.sv - self-synchronising 5-bit XNOR PRBS checker for DDR bit pairs
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        synchronous clear of bit_count, err_count, err_seen
//   in_valid   d_rise/d_fall carry a new sample pair
//   d_rise     first bit in stream order
//   d_fall     second bit in stream order
//   locked     FSM is in LOCKED
//   err_pulse  one-cycle pulse after a cycle with counted mismatches
//   err_seen   sticky counted-error flag
//   bit_count  saturating count of bits checked while LOCKED
//   err_count  saturating count of mismatching bits while LOCKED
//   state      FSM encoding (FILL=0, HUNT=1, LOCKED=2)
module ddr_prbs_checker #(
  parameter int CNT_W     = 16,
  parameter int LOCK_GOOD = 8,
  parameter int LOSS_ERR  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             d_rise,
  input  logic             d_fall,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_seen,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef logic [CNT_W:0] cnt_ext_t;

  localparam logic [7:0]       GOOD_LAST = 8'(LOCK_GOOD - 1);
  localparam logic [6:0]       LOSS_TH   = 7'(LOSS_ERR);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     st, st_nxt;
  logic [4:0] h;
  logic [1:0] fill_cnt, fill_nxt;
  logic [7:0] good_cnt, good_nxt;
  logic [4:0] win_cnt, win_cnt_nxt;
  logic [6:0] win_err, win_err_nxt;

  logic       exp_r, exp_f, err_r, err_f, stuck, good;
  logic [2:0] err_w;
  logic [7:0] win_sum;
  logic [6:0] win_err_upd;
  logic       lose;
  logic       count_en;
  cnt_ext_t   bit_sum, err_sum;

  // Both predictions come from received bits. For the falling bit the tap
  // vector is {h[3:0], d_rise}, whose taps [4] and [2] are h[3] and h[1].
  assign exp_r = ~(h[4] ^ h[2]);
  assign exp_f = ~(h[3] ^ h[1]);
  assign err_r = d_rise ^ exp_r;
  assign err_f = d_fall ^ exp_f;

  // All-ones is the XNOR lock-up state: it predicts itself, so treat it as bad.
  assign stuck = (h == 5'h1f) && d_rise && d_fall;
  assign good  = !err_r && !err_f && !stuck;
  assign err_w = {2'b00, err_r} + {2'b00, err_f} + {1'b0, stuck, 1'b0};

  assign win_sum     = {1'b0, win_err} + {5'd0, err_w};
  assign win_err_upd = win_sum[7] ? 7'h7f : win_sum[6:0];
  assign lose        = (win_err_upd >= LOSS_TH);

  assign bit_sum = {1'b0, bit_count} + cnt_ext_t'(2);
  assign err_sum = {1'b0, err_count} + cnt_ext_t'(err_w);

  always_comb begin
    st_nxt      = st;
    fill_nxt    = fill_cnt;
    good_nxt    = good_cnt;
    win_cnt_nxt = win_cnt;
    win_err_nxt = win_err;
    count_en    = 1'b0;
    case (st)
      FILL: begin
        if (in_valid) begin
          if (fill_cnt == 2'd2) begin
            st_nxt   = HUNT;
            fill_nxt = 2'd0;
          end else begin
            fill_nxt = fill_cnt + 2'd1;
          end
        end
      end
      HUNT: begin
        if (in_valid) begin
          if (!good) begin
            good_nxt = 8'd0;
          end else if (good_cnt == GOOD_LAST) begin
            st_nxt      = LOCKED;
            good_nxt    = 8'd0;
            win_cnt_nxt = 5'd0;
            win_err_nxt = 7'd0;
          end else begin
            good_nxt = good_cnt + 8'd1;
          end
        end
      end
      LOCKED: begin
        if (in_valid) begin
          count_en    = 1'b1;
          win_cnt_nxt = win_cnt + 5'd1;
          if (lose) begin
            st_nxt      = HUNT;
            good_nxt    = 8'd0;
            win_err_nxt = win_err_upd;
          end else if (win_cnt == 5'd31) begin
            win_err_nxt = 7'd0;
          end else begin
            win_err_nxt = win_err_upd;
          end
        end
      end
      default: st_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= FILL;
      h         <= 5'd0;
      fill_cnt  <= 2'd0;
      good_cnt  <= 8'd0;
      win_cnt   <= 5'd0;
      win_err   <= 7'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_seen  <= 1'b0;
      bit_count <= '0;
      err_count <= '0;
    end else begin
      st       <= st_nxt;
      fill_cnt <= fill_nxt;
      good_cnt <= good_nxt;
      win_cnt  <= win_cnt_nxt;
      win_err  <= win_err_nxt;
      locked   <= (st_nxt == LOCKED);
      if (in_valid) begin
        h <= {h[2:0], d_rise, d_fall};
      end
      // The pulse is not masked by clr: the error still happened on the line.
      err_pulse <= count_en && (err_w != 3'd0);
      if (clr) begin
        bit_count <= '0;
        err_count <= '0;
        err_seen  <= 1'b0;
      end else if (count_en) begin
        bit_count <= bit_sum[CNT_W] ? CNT_MAX : bit_sum[CNT_W-1:0];
        err_count <= err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];
        if (err_w != 3'd0) begin
          err_seen <= 1'b1;
        end
      end
    end
  end

  assign state = st;

endmodule
